mp5_pop_scheduler: RTL and testbench

Timestamp-ordered pop scheduler for one MP5 stage: tracks occupancy and enqueue timestamps of the stage's NUM_PIPELINES per-source FIFOs, allocates tail slots on push, and issues one pop per accepted handshake from the FIFO whose head entry is oldest. It sits beside the stage packet store and drives its read address and steering; the packet payload never passes through this block.

---
 rtl/mp5_pop_scheduler_if.sv | 28 ++
 rtl/mp5_pop_scheduler.sv | 102 ++++++++++
 tb/tb_mp5_pop_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mp5_pop_scheduler_if.sv
// mp5_pop_scheduler_if: push/pop handshake, status flags and timestamp of the MP5 pop scheduler.
interface mp5_pop_scheduler_if #(
  parameter int NUM_PIPELINES = 8,
  parameter int FIFO_SIZE = 8,
  parameter int TS_WIDTH = 16
);
  localparam int IW = $clog2(NUM_PIPELINES);
  localparam int AW = $clog2(FIFO_SIZE);
  logic push_valid;
  logic [IW-1:0] push_fifo_id;
  logic push_ack;
  logic [AW-1:0] push_addr;
  logic [NUM_PIPELINES-1:0] full;
  logic [NUM_PIPELINES-1:0] empty;
  logic pop_valid;
  logic [IW-1:0] pop_fifo_id;
  logic [AW-1:0] pop_addr;
  logic pop_ready;
  logic [TS_WIDTH-1:0] curr_time;
  modport master (
    output push_valid, push_fifo_id, pop_ready,
    input push_ack, push_addr, full, empty, pop_valid, pop_fifo_id, pop_addr, curr_time
  );
  modport slave (
    input push_valid, push_fifo_id, pop_ready,
    output push_ack, push_addr, full, empty, pop_valid, pop_fifo_id, pop_addr, curr_time
  );
endinterface

// File: rtl/mp5_pop_scheduler.sv
// mp5_pop_scheduler: oldest-head-first pop scheduler over per-source FIFO bookkeeping.
// Define MP5_SCHED_TIE_RR_EN for round-robin tie-break; default is lowest index.
module mp5_pop_scheduler #(
  parameter int NUM_PIPELINES = 8,
  parameter int FIFO_SIZE = 8,
  parameter int TS_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  mp5_pop_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_PIPELINES);
  localparam int AW = $clog2(FIFO_SIZE);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_n;
  logic [AW-1:0] head [NUM_PIPELINES];
  logic [AW-1:0] tail [NUM_PIPELINES];
  logic [CW-1:0] count [NUM_PIPELINES];
  logic [TS_WIDTH-1:0] ts [NUM_PIPELINES][FIFO_SIZE];
  logic [TS_WIDTH-1:0] curr_time, age, best;
  logic [IW-1:0] pop_fifo_id, win, base, idx;
  logic [AW-1:0] pop_addr;
  logic [NUM_PIPELINES-1:0] full, empty, push_hit, pop_hit;
  logic found, load, do_pop, push_ack;
  for (genvar i = 0; i < NUM_PIPELINES; i++) begin : g_fifo
    assign full[i] = count[i] == CW'(FIFO_SIZE);
    assign empty[i] = count[i] == '0;
    assign push_hit[i] = push_ack && bus.push_fifo_id == IW'(i);
    assign pop_hit[i] = do_pop && win == IW'(i);
  end
  assign push_ack = bus.push_valid && !full[bus.push_fifo_id];
  assign bus.push_ack = push_ack;
  assign bus.push_addr = tail[bus.push_fifo_id];
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.pop_valid = state == HOLD;
  assign bus.pop_fifo_id = pop_fifo_id;
  assign bus.pop_addr = pop_addr;
  assign bus.curr_time = curr_time;
`ifdef MP5_SCHED_TIE_RR_EN
  logic [IW-1:0] rr_ptr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr <= '0;
    else if (do_pop) rr_ptr <= win + IW'(1);
  end
  assign base = rr_ptr;
`else
  assign base = '0;
`endif
  // Scan from base so strict '>' keeps the first tied FIFO at or after base.
  always_comb begin
    found = 1'b0;
    win = '0;
    best = '0;
    idx = '0;
    age = '0;
    for (int k = 0; k < NUM_PIPELINES; k++) begin
      idx = base + IW'(k);
      age = curr_time - ts[idx][head[idx]];
      if (!empty[idx] && (!found || age > best)) begin
        found = 1'b1;
        win = idx;
        best = age;
      end
    end
  end
  assign load = state == IDLE || bus.pop_ready;
  always_comb begin
    do_pop = load && found;
    state_n = load ? (found ? HOLD : IDLE) : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      curr_time <= '0;
      pop_fifo_id <= '0;
      pop_addr <= '0;
      for (int p = 0; p < NUM_PIPELINES; p++) begin
        head[p] <= '0;
        tail[p] <= '0;
        count[p] <= '0;
      end
    end else begin
      state <= state_n;
      curr_time <= curr_time + TS_WIDTH'(1);
      if (do_pop) begin
        pop_fifo_id <= win;
        pop_addr <= head[win];
      end
      for (int p = 0; p < NUM_PIPELINES; p++) begin
        head[p] <= head[p] + AW'(pop_hit[p]);
        tail[p] <= tail[p] + AW'(push_hit[p]);
        count[p] <= count[p] + CW'(push_hit[p]) - CW'(pop_hit[p]);
      end
    end
  end
  // Timestamp ring is not reset: count alone marks which slots are live.
  always_ff @(posedge clk) begin
    if (push_ack) ts[bus.push_fifo_id][tail[bus.push_fifo_id]] <= curr_time;
  end
endmodule

// File: tb/tb_mp5_pop_scheduler.sv
// tb_mp5_pop_scheduler: vector table, queue-based reference model with random traffic, and
// hand sequences for backpressure, timestamp ties, timestamp wrap and asynchronous reset.
module tb_mp5_pop_scheduler;
  localparam int NP = 8;
  localparam int FS = 8;
  logic clk, rst;
  int pv, pid, pr, pv4, pid4, pr4;
  int n_tests, n_fail, cyc;
  int mq_ts [NP][$];
  int mq_slot [NP][$];
  int mtail [NP];
  int m_valid, m_id, m_addr, m_time, m_rr;
  typedef struct {
    int pv, pid, pr, ack, addr, vld, id, pa;
  } vec_t;
  vec_t tbl [8];
  int t1_id, t1_addr, t2_id, t2_addr;

  mp5_pop_scheduler_if #(.NUM_PIPELINES(NP), .FIFO_SIZE(FS), .TS_WIDTH(16)) b16 ();
  mp5_pop_scheduler_if #(.NUM_PIPELINES(NP), .FIFO_SIZE(FS), .TS_WIDTH(4)) b4 ();
  mp5_pop_scheduler #(.NUM_PIPELINES(NP), .FIFO_SIZE(FS), .TS_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(b16));
  mp5_pop_scheduler #(.NUM_PIPELINES(NP), .FIFO_SIZE(FS), .TS_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  assign b16.push_valid = pv != 0;
  assign b16.push_fifo_id = 3'(pid);
  assign b16.pop_ready = pr != 0;
  assign b4.push_valid = pv4 != 0;
  assign b4.push_fifo_id = 3'(pid4);
  assign b4.pop_ready = pr4 != 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NP; i++) begin
      mq_ts[i].delete();
      mq_slot[i].delete();
      mtail[i] = 0;
    end
    m_valid = 0; m_id = 0; m_addr = 0; m_time = 0; m_rr = 0;
  endtask

  // Compare the 16-bit instance with the model, advance the model by one edge, then the clock.
  task automatic tick();
    int ee, ef, ack, best, bage, age, i;
    #1;
    ee = 0; ef = 0;
    for (int f = 0; f < NP; f++) begin
      if (mq_ts[f].size() == 0) ee |= 1 << f;
      if (mq_ts[f].size() == FS) ef |= 1 << f;
    end
    ack = (pv != 0 && mq_ts[pid].size() < FS) ? 1 : 0;
    chk("curr_time", 32'(b16.curr_time), m_time);
    chk("empty", 32'(b16.empty), ee);
    chk("full", 32'(b16.full), ef);
    chk("push_ack", 32'(b16.push_ack), ack);
    if (ack != 0) chk("push_addr", 32'(b16.push_addr), mtail[pid]);
    chk("pop_valid", 32'(b16.pop_valid), m_valid);
    if (m_valid != 0) begin
      chk("pop_fifo_id", 32'(b16.pop_fifo_id), m_id);
      chk("pop_addr", 32'(b16.pop_addr), m_addr);
    end
    if (m_valid == 0 || pr != 0) begin
      best = -1; bage = 0;
      for (int k = 0; k < NP; k++) begin
        i = (m_rr + k) % NP;
        if (mq_ts[i].size() > 0) begin
          age = (m_time - mq_ts[i][0]) & 16'hFFFF;
          if (best < 0 || age > bage) begin best = i; bage = age; end
        end
      end
      if (best >= 0) begin
        m_valid = 1; m_id = best;
        m_addr = mq_slot[best].pop_front();
        void'(mq_ts[best].pop_front());
`ifdef MP5_SCHED_TIE_RR_EN
        m_rr = (best + 1) % NP;
`endif
      end else m_valid = 0;
    end
    if (ack != 0) begin
      mq_ts[pid].push_back(m_time);
      mq_slot[pid].push_back(mtail[pid]);
      mtail[pid] = (mtail[pid] + 1) % FS;
    end
    m_time = (m_time + 1) & 16'hFFFF;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pv = 0; pid = 0; pr = 0; pv4 = 0; pid4 = 0; pr4 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_clear();
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    tbl[0] = '{0, 0, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 5, 1, 1, 0, 0, 0, 0};
    tbl[3] = '{1, 1, 1, 1, 0, 0, 0, 0};
    tbl[4] = '{1, 5, 1, 1, 1, 1, 5, 0};
    tbl[5] = '{0, 0, 1, 0, 0, 1, 1, 0};
    tbl[6] = '{0, 0, 1, 0, 0, 1, 5, 1};
    tbl[7] = '{0, 0, 1, 0, 0, 0, 0, 0};
`ifdef MP5_SCHED_TIE_RR_EN
    t1_id = 6; t1_addr = 0; t2_id = 3; t2_addr = 1;
`else
    t1_id = 3; t1_addr = 1; t2_id = 6; t2_addr = 0;
`endif
    do_reset();
    #1;
    chk("rst_pop_valid", 32'(b16.pop_valid), 0);
    chk("rst_empty", 32'(b16.empty), 255);
    chk("rst_full", 32'(b16.full), 0);
    chk("rst_curr_time", 32'(b16.curr_time), 0);
    chk("rst_push_addr", 32'(b16.push_addr), 0);
    chk("rst_empty4", 32'(b4.empty), 255);
    chk("rst_pop_addr", 32'(b16.pop_addr), 0);
    // Timestamp order: FIFO 5 at t=2, FIFO 1 at t=3, FIFO 5 at t=4.
    for (int r = 0; r < 8; r++) begin
      pv = tbl[r].pv; pid = tbl[r].pid; pr = tbl[r].pr;
      #1;
      chk("vec_ack", 32'(b16.push_ack), tbl[r].ack);
      if (tbl[r].ack != 0) chk("vec_push_addr", 32'(b16.push_addr), tbl[r].addr);
      chk("vec_pop_valid", 32'(b16.pop_valid), tbl[r].vld);
      if (tbl[r].vld != 0) begin
        chk("vec_pop_id", 32'(b16.pop_fifo_id), tbl[r].id);
        chk("vec_pop_addr", 32'(b16.pop_addr), tbl[r].pa);
      end
      tick();
    end
    // Backpressure: the committed pop frees one slot, so nine pushes fit and the tenth is refused.
    pr = 0;
    for (int k = 0; k < 10; k++) begin
      pv = 1; pid = 2;
      #1;
      chk("bp_ack", 32'(b16.push_ack), k < 9 ? 1 : 0);
      if (k < 9) chk("bp_push_addr", 32'(b16.push_addr), k % 8);
      if (k == 9) chk("bp_full2", 32'(b16.full[2]), 1);
      if (k >= 2) begin
        chk("bp_hold_valid", 32'(b16.pop_valid), 1);
        chk("bp_hold_id", 32'(b16.pop_fifo_id), 2);
        chk("bp_hold_addr", 32'(b16.pop_addr), 0);
      end
      tick();
    end
    pv = 0; pr = 1;
    repeat (10) tick();
    // Random traffic, from heavy backpressure to free-flowing consumer.
    for (int ep = 0; ep < 4; ep++) begin
      for (int n = 0; n < 500; n++) begin
        pv = ($urandom % 3) != 0 ? 1 : 0;
        pid = $urandom % NP;
        pr = ($urandom % 4) <= ep ? 1 : 0;
        tick();
      end
    end
    // Tie on the 4-bit instance: entries 16 cycles apart carry equal timestamps.
    do_reset();
    pv4 = 1; pid4 = 3;
    tick();
    #1;
    chk("tie_push_addr", 32'(b4.push_addr), 1);
    tick();
    pv4 = 0;
    for (int i = 2; i < 17; i++) tick();
    pv4 = 1; pid4 = 6;
    #1;
    chk("tie_ack6", 32'(b4.push_ack), 1);
    chk("tie_hold_id", 32'(b4.pop_fifo_id), 3);
    tick();
    pv4 = 0; pr4 = 1;
    #1;
    chk("tie_held_valid", 32'(b4.pop_valid), 1);
    chk("tie_held_addr", 32'(b4.pop_addr), 0);
    tick();
    chk("tie_first_id", 32'(b4.pop_fifo_id), t1_id);
    chk("tie_first_addr", 32'(b4.pop_addr), t1_addr);
    tick();
    chk("tie_second_id", 32'(b4.pop_fifo_id), t2_id);
    chk("tie_second_addr", 32'(b4.pop_addr), t2_addr);
    tick();
    chk("tie_drained", 32'(b4.pop_valid), 0);
    // Wrap: FIFO 0 stamped 14, FIFO 1 stamped 1 after wrap; FIFO 0 is older.
    pr4 = 0; pv4 = 1; pid4 = 7;
    tick();
    pv4 = 0;
    while (cyc % 16 != 14) tick();
    pv4 = 1; pid4 = 0;
    tick();
    pv4 = 0;
    while (cyc % 16 != 1) tick();
    pv4 = 1; pid4 = 1;
    tick();
    pv4 = 0; pr4 = 1;
    #1;
    chk("wrap_hold_id", 32'(b4.pop_fifo_id), 7);
    tick();
    chk("wrap_first_id", 32'(b4.pop_fifo_id), 0);
    chk("wrap_first_valid", 32'(b4.pop_valid), 1);
    tick();
    chk("wrap_second_id", 32'(b4.pop_fifo_id), 1);
    tick();
    chk("wrap_drained", 32'(b4.pop_valid), 0);
    pr4 = 0;
    // Asynchronous reset with a held pop and queued entries.
    pr = 0;
    for (int k = 1; k <= 4; k++) begin
      pv = 1; pid = k;
      tick();
    end
    pv = 0;
    #1;
    chk("mid_before_valid", 32'(b16.pop_valid), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_pop_valid", 32'(b16.pop_valid), 0);
    chk("mid_empty", 32'(b16.empty), 255);
    chk("mid_full", 32'(b16.full), 0);
    chk("mid_curr_time", 32'(b16.curr_time), 0);
    chk("mid_empty4", 32'(b4.empty), 255);
    do_reset();
    pr = 1;
    for (int n = 0; n < 40; n++) begin
      pv = $urandom % 2;
      pid = $urandom % NP;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
